core_rf_scoreboard: RTL and testbench
=====================================

// Module: core_rf_scoreboard
// PURPOSE
//  Scoreboard and register-file write-port arbiter for long-latency ops (mul/div).
//  Tracks destination registers of in-flight long ops and stalls ID on RAW/WAW/structural hazards.
//  Shares the single RF write port between pipeline WB (fixed priority) and long-unit results,
//  buffering displaced results in an in-order FIFO. Sits beside core_id_stage and drives its RF write inputs.
// PARAMETERS
//  XLEN      32  data width
//  NUM_REGS  32  architectural registers (x0 hardwired zero)
//  MAX_OUT   2   max long ops in flight plus buffered (>=1)
// PORTS
//  i_clk           in   1        clock
//  i_rst_n         in   1        async active-low reset
//  i_id_valid      in   1        valid instruction in ID
//  i_id_rs1        in   5        ID source 1
//  i_id_rs2        in   5        ID source 2
//  i_id_rd         in   5        ID destination
//  i_id_uses_rs1   in   1        instr reads rs1
//  i_id_uses_rs2   in   1        instr reads rs2
//  i_id_reg_write  in   1        instr writes rd
//  i_id_long       in   1        instr goes to long-latency unit
//  o_id_stall      out  1        hold ID/IF this cycle
//  o_lu_issue      out  1        1-cycle pulse: long op leaves ID
//  i_lu_done       in   1        1-cycle pulse: long result valid (in issue order)
//  i_lu_rd         in   5        long result destination
//  i_lu_data       in   XLEN     long result data
//  i_wb_reg_write  in   1        pipeline WB write enable
//  i_wb_rd         in   5        pipeline WB destination
//  i_wb_data       in   XLEN     pipeline WB data
//  o_rf_we         out  1        RF write enable
//  o_rf_rd         out  5        RF write address
//  o_rf_din        out  XLEN     RF write data
//  o_sb_err        out  1        sticky: i_lu_done while count==0
// BEHAVIOUR
//  Reset (async, i_rst_n=0): pending[]=0, count=0, FIFO empty, o_sb_err=0; hence o_id_stall=0,
//   o_lu_issue=0, o_rf_we=i_wb_reg_write. Reset mid-operation discards in-flight/buffered results.
//  Stall (comb from registered state): i_id_valid & (
//   (uses_rs1 & rs1!=0 & pending[rs1]) | (uses_rs2 & rs2!=0 & pending[rs2]) |
//   (reg_write & rd!=0 & pending[rd]) | (i_id_long & count==MAX_OUT)).
//  issue = i_id_valid & ~o_id_stall; o_lu_issue = issue & i_id_long.
//  On o_lu_issue: count+1; if reg_write & rd!=0, pending[rd] set at next edge.
//  Port busy = i_wb_reg_write & i_wb_rd!=0. WB always wins; o_rf_* = WB when busy.
//  Long result retire, when port free: FIFO head if non-empty (pop), else i_lu_done direct
//   (0-cycle bypass). i_lu_done not retired same cycle -> push {rd,data}.
//  i_lu_done with i_lu_rd==0: dropped on arrival, retires immediately, no RF write.
//  Retire of rd: o_rf_we=1, clear pending[rd] at edge, count-1. Issue+retire same cycle: count unchanged.
//  Pending clears at the edge of the RF write; ID sees it one cycle later (RF write visible next cycle).
//  FIFO depth MAX_OUT; cannot overflow since count covers in-flight+buffered. Order preserved.
//  Pipeline ops are not scoreboarded (forwarding covers them). Long-unit latency must be >=3 cycles,
//   so older pipeline writes to the same rd land first.
//  i_lu_done with count==0: ignored, o_sb_err<=1 until reset.
// STRUCTURE
//  core_pkg: REG_ADDR_W=5, typedef lu_result_t {logic[4:0] rd; logic[XLEN-1:0] data;}.
//  Sub-module core_sb_fifo: sync FIFO (push/pop/full/empty, head data), async active-low reset.
//  Top: pending vector, count register, stall logic, write-port mux.
// TESTING
//  long issue rd=x5; next instr uses rs1=x5 -> o_id_stall=1 until cycle after retire of x5.
//  i_lu_done rd=x5 data=0xDEADBEEF, WB idle, FIFO empty -> same-cycle o_rf_we=1, rd=5, din=0xDEADBEEF.
//  i_lu_done rd=x6 while WB writes x7 for 2 cycles -> WB writes x7 both cycles; x6 written cycle 3.
//  MAX_OUT=2: two long issues, third long instr -> stall until first retire; count never >2.
//  long op rd=x0 -> pending unchanged, done dropped, count returns to 0, o_rf_we=0 for it.
//  i_lu_done with count=0 -> o_sb_err=1 sticky; async reset mid-HOLD -> FIFO empty, stall=0, err=0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the core register-file scoreboard slice.
//   REG_ADDR_W  : architectural register address width
//   LU_XLEN     : default long-unit result data width
//   lu_result_t : {rd, data} record of one long-unit result
//   reg_nz()    : true when a register address is not x0
package core_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int LU_XLEN    = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [LU_XLEN-1:0]    data;
    } lu_result_t;

    function automatic logic reg_nz(input logic [REG_ADDR_W-1:0] r);
        return (r != '0);
    endfunction

endpackage

// File: rtl/core_sb_fifo.sv
// Small synchronous FIFO holding long-unit results displaced from the RF
// write port. Order is preserved; the head entry is always visible.
//   i_clk, i_rst_n : clock, async active-low reset (pointers/count only)
//   i_push, i_din  : write one entry (ignored when full and not popping)
//   i_pop          : remove the head entry (ignored when empty)
//   o_head         : current head entry
//   o_full/o_empty : occupancy flags
module core_sb_fifo
    import core_pkg::*;
#(
    parameter int W     = REG_ADDR_W + LU_XLEN,
    parameter int DEPTH = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output logic         o_full,
    output logic         o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [CNT_W-1:0] r_cnt;

    logic w_do_push;
    logic w_do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_full    = (r_cnt == CNT_W'(DEPTH));
    assign o_empty   = (r_cnt == '0);
    assign w_do_pop  = i_pop & ~o_empty;
    // A full FIFO may still accept an entry in the cycle its head leaves.
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_head    = r_mem[r_rd];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_do_push) r_wr <= ptr_inc(r_wr);
            if (w_do_pop)  r_rd <= ptr_inc(r_rd);
            r_cnt <= r_cnt + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    // Storage carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr] <= i_din;
    end

endmodule

// File: rtl/core_rf_scoreboard.sv
// Scoreboard for long-latency ops plus RF write-port arbiter.
// Tracks destinations of in-flight long ops, stalls ID on RAW/WAW hazards
// and on a full long-op budget, and shares the single RF write port between
// pipeline WB (always wins) and long-unit results (buffered in order).
//   ID side   : i_id_valid/rs1/rs2/rd/uses_rs1/uses_rs2/reg_write/long,
//               o_id_stall, o_lu_issue
//   Long unit : i_lu_done, i_lu_rd, i_lu_data
//   WB side   : i_wb_reg_write, i_wb_rd, i_wb_data
//   RF port   : o_rf_we, o_rf_rd, o_rf_din
//   o_sb_err  : sticky, a long result arrived with nothing in flight
module core_rf_scoreboard
    import core_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int MAX_OUT  = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_id_valid,
    input  logic [REG_ADDR_W-1:0] i_id_rs1,
    input  logic [REG_ADDR_W-1:0] i_id_rs2,
    input  logic [REG_ADDR_W-1:0] i_id_rd,
    input  logic                  i_id_uses_rs1,
    input  logic                  i_id_uses_rs2,
    input  logic                  i_id_reg_write,
    input  logic                  i_id_long,
    output logic                  o_id_stall,
    output logic                  o_lu_issue,
    input  logic                  i_lu_done,
    input  logic [REG_ADDR_W-1:0] i_lu_rd,
    input  logic [XLEN-1:0]       i_lu_data,
    input  logic                  i_wb_reg_write,
    input  logic [REG_ADDR_W-1:0] i_wb_rd,
    input  logic [XLEN-1:0]       i_wb_data,
    output logic                  o_rf_we,
    output logic [REG_ADDR_W-1:0] o_rf_rd,
    output logic [XLEN-1:0]       o_rf_din,
    output logic                  o_sb_err
);

    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam int ENT_W = REG_ADDR_W + XLEN;

    logic [NUM_REGS-1:0] r_pending;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_err;

    logic                  w_cnt_full;
    logic                  w_hz;
    logic                  w_issue;
    logic                  w_port_busy;
    logic                  w_done_ok;
    logic                  w_done_nz;
    logic                  w_done_drop;
    logic                  w_fifo_empty;
    logic                  w_fifo_full;
    logic                  w_pop;
    logic                  w_direct;
    logic                  w_push;
    logic                  w_ret;
    logic [ENT_W-1:0]      w_head;
    logic [REG_ADDR_W-1:0] w_ret_rd;
    logic [XLEN-1:0]       w_ret_data;
    logic [CNT_W-1:0]      w_dec;

    // Hazards are evaluated purely from registered scoreboard state, so a
    // retire this cycle only releases ID on the following cycle.
    assign w_cnt_full = (r_cnt == CNT_W'(MAX_OUT));
    assign w_hz = (i_id_uses_rs1  & reg_nz(i_id_rs1) & r_pending[i_id_rs1]) |
                  (i_id_uses_rs2  & reg_nz(i_id_rs2) & r_pending[i_id_rs2]) |
                  (i_id_reg_write & reg_nz(i_id_rd)  & r_pending[i_id_rd])  |
                  (i_id_long & w_cnt_full);

    assign o_id_stall = i_id_valid & w_hz;
    assign w_issue    = i_id_valid & ~o_id_stall;
    assign o_lu_issue = w_issue & i_id_long;

    // Writes to x0 do not occupy the port, so a long result may retire.
    assign w_port_busy = i_wb_reg_write & reg_nz(i_wb_rd);

    // A result with nothing outstanding is spurious and discarded.
    assign w_done_ok   = i_lu_done & (r_cnt != '0);
    assign w_done_nz   = w_done_ok & reg_nz(i_lu_rd);
    assign w_done_drop = w_done_ok & ~reg_nz(i_lu_rd);

    // Buffered results are older than an arriving one, so they go first.
    assign w_pop    = ~w_port_busy & ~w_fifo_empty;
    assign w_direct = ~w_port_busy & w_fifo_empty & w_done_nz;
    assign w_push   = w_done_nz & ~w_direct & (~w_fifo_full | w_pop);
    assign w_ret    = w_pop | w_direct;

    assign w_ret_rd   = w_pop ? w_head[ENT_W-1:XLEN] : i_lu_rd;
    assign w_ret_data = w_pop ? w_head[XLEN-1:0]     : i_lu_data;

    core_sb_fifo #(
        .W     (ENT_W),
        .DEPTH (MAX_OUT)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_din   ({i_lu_rd, i_lu_data}),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_comb begin
        o_rf_we  = i_wb_reg_write;
        o_rf_rd  = i_wb_rd;
        o_rf_din = i_wb_data;
        if (!w_port_busy && w_ret) begin
            o_rf_we  = 1'b1;
            o_rf_rd  = w_ret_rd;
            o_rf_din = w_ret_data;
        end
    end

    // A dropped x0 result and a FIFO pop can both retire in one cycle.
    assign w_dec = CNT_W'(w_ret) + CNT_W'(w_done_drop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pending <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(o_lu_issue) - w_dec;
            if (w_ret) r_pending[w_ret_rd] <= 1'b0;
            if (o_lu_issue && i_id_reg_write && reg_nz(i_id_rd))
                r_pending[i_id_rd] <= 1'b1;
            if (i_lu_done && (r_cnt == '0)) r_err <= 1'b1;
        end
    end

    assign o_sb_err = r_err;

endmodule

// File: tb/tb_core_rf_scoreboard.sv
module tb_core_rf_scoreboard;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_u1, id_u2, id_rw, id_long;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_stall, lu_issue;
    logic        lu_done;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_din;
    logic        sb_err;

    int n_vec = 0;
    int n_err = 0;
    lu_result_t exp_q[$];

    always #5 clk = ~clk;

    core_rf_scoreboard #(.XLEN(32), .NUM_REGS(32), .MAX_OUT(2)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_id_valid     (id_valid),
        .i_id_rs1       (id_rs1),
        .i_id_rs2       (id_rs2),
        .i_id_rd        (id_rd),
        .i_id_uses_rs1  (id_u1),
        .i_id_uses_rs2  (id_u2),
        .i_id_reg_write (id_rw),
        .i_id_long      (id_long),
        .o_id_stall     (id_stall),
        .o_lu_issue     (lu_issue),
        .i_lu_done      (lu_done),
        .i_lu_rd        (lu_rd),
        .i_lu_data      (lu_data),
        .i_wb_reg_write (wb_we),
        .i_wb_rd        (wb_rd),
        .i_wb_data      (wb_data),
        .o_rf_we        (rf_we),
        .o_rf_rd        (rf_rd),
        .o_rf_din       (rf_din),
        .o_sb_err       (sb_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        id_valid = 0; id_u1 = 0; id_u2 = 0; id_rw = 0; id_long = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        lu_done = 0; lu_rd = 0; lu_data = 0;
        wb_we = 0; wb_rd = 0; wb_data = 0;
    endtask

    task automatic id_set(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rd, input logic rw, input logic lng);
        id_valid = v; id_rs1 = rs1; id_u1 = u1; id_rs2 = 0; id_u2 = 0;
        id_rd = rd; id_rw = rw; id_long = lng;
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d);
        lu_result_t e;
        e.rd = rd;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every RF write must match the oldest expected write.
    initial begin
        lu_result_t e;
        forever begin
            @(negedge clk);
            if (rf_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL rf_unexpected: got write rd=%0d din=0x%0h expected no write", rf_rd, rf_din);
                end else begin
                    e = exp_q.pop_front();
                    chk("mon_rf_rd", 64'(rf_rd), 64'(e.rd));
                    chk("mon_rf_din", 64'(rf_din), 64'(e.data));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst_n = 0;
        // Reset state
        @(negedge clk);
        chk("rst_stall", 64'(id_stall), 0);
        chk("rst_issue", 64'(lu_issue), 0);
        chk("rst_err", 64'(sb_err), 0);
        chk("rst_rf_we", 64'(rf_we), 0);
        nxt();
        rst_n = 1;
        nxt();

        // RAW on a long destination, direct same-cycle retire
        id_set(1, 0, 0, 5, 1, 1);
        @(negedge clk);
        chk("t1_no_stall", 64'(id_stall), 0);
        chk("t1_lu_issue", 64'(lu_issue), 1);
        nxt();
        id_set(1, 5, 1, 8, 1, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t1_raw_stall", 64'(id_stall), 1);
            chk("t1_no_issue", 64'(lu_issue), 0);
            nxt();
        end
        lu_done = 1; lu_rd = 5; lu_data = 32'hDEADBEEF;
        expect_wr(5, 32'hDEADBEEF);
        @(negedge clk);
        chk("t1_bypass_we", 64'(rf_we), 1);
        chk("t1_bypass_rd", 64'(rf_rd), 5);
        chk("t1_bypass_din", 64'(rf_din), 64'hDEADBEEF);
        chk("t1_stall_retire_cycle", 64'(id_stall), 1);
        nxt();
        lu_done = 0;
        @(negedge clk);
        chk("t1_stall_released", 64'(id_stall), 0);
        chk("t1_short_no_issue", 64'(lu_issue), 0);
        nxt();
        idle();

        // WB owns the port for two cycles, long result buffered
        id_set(1, 0, 0, 6, 1, 1);
        @(negedge clk);
        chk("t2_issue", 64'(lu_issue), 1);
        nxt();
        idle();
        nxt();
        wb_we = 1; wb_rd = 7; wb_data = 32'h77770001;
        expect_wr(7, 32'h77770001);
        lu_done = 1; lu_rd = 6; lu_data = 32'h66666666;
        @(negedge clk);
        chk("t2_wb_c1_rd", 64'(rf_rd), 7);
        nxt();
        lu_done = 0; wb_data = 32'h77770002;
        expect_wr(7, 32'h77770002);
        @(negedge clk);
        chk("t2_wb_c2_rd", 64'(rf_rd), 7);
        nxt();
        wb_we = 0; wb_rd = 0; wb_data = 0;
        expect_wr(6, 32'h66666666);
        @(negedge clk);
        chk("t2_fifo_we", 64'(rf_we), 1);
        chk("t2_fifo_rd", 64'(rf_rd), 6);
        nxt();

        // Structural limit of two outstanding long ops
        id_set(1, 0, 0, 10, 1, 1);
        @(negedge clk);
        chk("t3_issue_a", 64'(lu_issue), 1);
        nxt();
        id_set(1, 0, 0, 11, 1, 1);
        @(negedge clk);
        chk("t3_issue_b", 64'(lu_issue), 1);
        nxt();
        id_set(1, 0, 0, 12, 1, 1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t3_full_stall", 64'(id_stall), 1);
            nxt();
        end
        lu_done = 1; lu_rd = 10; lu_data = 32'hA0A0A0A0;
        expect_wr(10, 32'hA0A0A0A0);
        @(negedge clk);
        chk("t3_stall_on_retire", 64'(id_stall), 1);
        nxt();
        lu_done = 0;
        @(negedge clk);
        chk("t3_released", 64'(id_stall), 0);
        chk("t3_issue_c", 64'(lu_issue), 1);
        nxt();
        id_set(1, 0, 0, 14, 1, 1);
        @(negedge clk);
        chk("t3_full_again", 64'(id_stall), 1);
        nxt();
        idle();
        lu_done = 1; lu_rd = 11; lu_data = 32'hB1B1B1B1;
        expect_wr(11, 32'hB1B1B1B1);
        nxt();
        lu_rd = 12; lu_data = 32'hC2C2C2C2;
        expect_wr(12, 32'hC2C2C2C2);
        @(negedge clk);
        chk("t3_last_rd", 64'(rf_rd), 12);
        nxt();
        lu_done = 0;

        // Long op to x0: no pending bit, dropped result, count back to 0
        id_set(1, 0, 0, 0, 1, 1);
        @(negedge clk);
        chk("t4_issue_x0", 64'(lu_issue), 1);
        nxt();
        idle();
        nxt();
        lu_done = 1; lu_rd = 0; lu_data = 32'h00000123;
        @(negedge clk);
        chk("t4_x0_no_we", 64'(rf_we), 0);
        nxt();
        lu_done = 0;
        @(negedge clk);
        chk("t4_no_err", 64'(sb_err), 0);
        nxt();

        // Spurious done with nothing outstanding
        lu_done = 1; lu_rd = 3; lu_data = 32'h55;
        @(negedge clk);
        chk("t5_ignored_we", 64'(rf_we), 0);
        nxt();
        lu_done = 0;
        @(negedge clk);
        chk("t5_err_set", 64'(sb_err), 1);
        nxt();
        @(negedge clk);
        chk("t5_err_sticky", 64'(sb_err), 1);
        nxt();

        // Async reset while a result is held in the FIFO
        id_set(1, 0, 0, 9, 1, 1);
        nxt();
        id_set(1, 0, 0, 13, 1, 1);
        @(negedge clk);
        chk("t6_issue_b", 64'(lu_issue), 1);
        nxt();
        idle();
        nxt();
        wb_we = 1; wb_rd = 7; wb_data = 32'h70;
        expect_wr(7, 32'h70);
        lu_done = 1; lu_rd = 9; lu_data = 32'h99;
        nxt();
        lu_done = 0; wb_data = 32'h71;
        expect_wr(7, 32'h71);
        @(negedge clk);
        #2;
        rst_n = 0;
        idle();
        id_set(1, 13, 1, 20, 1, 0);
        #1;
        chk("t6_rst_stall", 64'(id_stall), 0);
        chk("t6_rst_err", 64'(sb_err), 0);
        chk("t6_rst_we", 64'(rf_we), 0);
        nxt();
        rst_n = 1;
        @(negedge clk);
        chk("t6_post_we", 64'(rf_we), 0);
        chk("t6_post_stall", 64'(id_stall), 0);
        nxt();
        idle();
        @(negedge clk);
        chk("t6_fifo_empty_we", 64'(rf_we), 0);
        nxt();

        repeat (3) nxt();
        chk("exp_q_drained", 64'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
